clk_period_monitor: RTL and testbench

- Receiving end of the divided-clock path: samples a slow clock produced elsewhere by a divider (S_CLK) in the fast I_CLK domain.
- Measures its period and high time in I_CLK cycles and checks the period against an expected divide ratio.
- Reports lock, loss and error status; used to self-check divider outputs on the board and in simulation.

---
 rtl/clk_period_monitor.sv | 160 ++++++++++++++++
 tb/tb_clk_period_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// Samples a divided clock in the I_CLK domain, measures its period and high
// time, and tracks lock/loss against an expected divide ratio.
module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             I_CLK,
  input  logic             rst_n,
  input  logic             S_CLK,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOCK,
  output logic             O_ERR,
  output logic             O_IDLE
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  // Lower bound clamps at zero when TOL exceeds EXP_PERIOD; the upper bound
  // carries an extra bit so EXP_PERIOD+TOL never wraps against the counter.
  localparam logic [CNT_W-1:0] TOL_LO  = (EXP_PERIOD > TOL) ? CNT_W'(EXP_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0]   TOL_HI  = (CNT_W + 1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rise, fall, in_tol, timeout;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign in_tol   = (cnt_q >= TOL_LO) && ({1'b0, cnt_q} <= TOL_HI);
  assign timeout  = (cnt_q == TMO_VAL);
  assign good_inc = good_q + 1'b1;

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= S_CLK;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (fall && (state_q != IDLE)) begin
      high_d = cnt_q;
    end

    // A rise always takes priority over a coincident timeout.
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (in_tol) begin
            good_d = good_inc;
            if (good_inc == LOCK_VAL) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
            err_d  = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          good_d  = '0;
          err_d   = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (!in_tol) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          good_d  = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  assign O_PERIOD = period_q;
  assign O_HIGH   = high_q;
  assign O_VALID  = valid_q;
  assign O_ERR    = err_q;
  assign O_LOCK   = (state_q == LOCKED);
  assign O_IDLE   = (state_q == IDLE);

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with default parameters; S_CLK is
// driven on falling I_CLK edges, results checked against hand-derived values.
module tb_clk_period_monitor;

  logic        I_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        S_CLK = 1'b0;
  logic [15:0] O_PERIOD, O_HIGH;
  logic        O_VALID, O_LOCK, O_ERR, O_IDLE;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0, vcnt = 0, ecnt = 0, lcnt = 0, last_v = 0, last_e = 0;
  int unsigned e0, v1, v2, e3, v3, l3, l0, c0;

  clk_period_monitor #(
    .CNT_W(16), .EXP_PERIOD(20), .TOL(1), .LOCK_CNT(4), .TIMEOUT(255)
  ) dut (
    .I_CLK(I_CLK), .rst_n(rst_n), .S_CLK(S_CLK),
    .O_PERIOD(O_PERIOD), .O_HIGH(O_HIGH), .O_VALID(O_VALID),
    .O_LOCK(O_LOCK), .O_ERR(O_ERR), .O_IDLE(O_IDLE)
  );

  always #5 I_CLK = ~I_CLK;

  // Pulse/lock bookkeeping, sampled shortly after each active edge.
  always @(posedge I_CLK) begin
    #2;
    cyc++;
    if (O_VALID === 1'b1) begin vcnt++; last_v = cyc; end
    if (O_ERR === 1'b1) begin ecnt++; last_e = cyc; end
    if (O_LOCK === 1'b1) lcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    S_CLK = v;
    repeat (n) @(negedge I_CLK);
  endtask

  task automatic per(input int p, input int h);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge I_CLK);
    chk("rst_idle", 32'(O_IDLE), 1);
    chk("rst_lock", 32'(O_LOCK), 0);
    chk("rst_valid", 32'(O_VALID), 0);
    chk("rst_err", 32'(O_ERR), 0);
    chk("rst_period", 32'(O_PERIOD), 0);
    chk("rst_high", 32'(O_HIGH), 0);
    rst_n = 1'b1;

    // S_CLK held constant: stays idle, no error
    drive(1'b0, 300);
    chk("hold_idle", 32'(O_IDLE), 1);
    chk("hold_no_err", ecnt, 0);
    chk("hold_no_valid", vcnt, 0);

    // Nominal 20-cycle clock: lock on 5th rise
    repeat (4) per(20, 10);
    chk("nom_not_locked_4", 32'(O_LOCK), 0);
    chk("nom_valid_4", vcnt, 3);
    per(20, 10);
    chk("nom_locked_5", 32'(O_LOCK), 1);
    chk("nom_valid_5", vcnt, 4);
    chk("nom_period", 32'(O_PERIOD), 20);
    chk("nom_high", 32'(O_HIGH), 10);
    chk("nom_no_err", ecnt, 0);
    chk("nom_not_idle", 32'(O_IDLE), 0);

    // One stretched period (23, high 12)
    e0 = ecnt;
    drive(1'b1, 12);
    drive(1'b0, 11);
    drive(1'b1, 4);
    chk("str_period", 32'(O_PERIOD), 23);
    chk("str_high", 32'(O_HIGH), 12);
    chk("str_lock_drop", 32'(O_LOCK), 0);
    chk("str_err_once", ecnt, e0 + 1);
    drive(1'b1, 6);
    drive(1'b0, 10);
    repeat (3) per(20, 10);
    chk("str_relock_3", 32'(O_LOCK), 0);
    drive(1'b1, 4);
    chk("str_relock_4", 32'(O_LOCK), 1);
    chk("str_err_total", ecnt, e0 + 1);

    // Alternating 19/21 periods stay locked
    l0 = lcnt; c0 = cyc;
    drive(1'b1, 6);
    drive(1'b0, 10);
    repeat (3) begin
      per(19, 10);
      per(21, 10);
    end
    drive(1'b1, 4);
    chk("alt_period", 32'(O_PERIOD), 21);
    chk("alt_lock", 32'(O_LOCK), 1);
    chk("alt_lock_held", lcnt - l0, cyc - c0);
    chk("alt_no_err", ecnt, e0 + 1);

    // S_CLK stops low: timeout 255 cycles after last rise
    drive(1'b1, 6);
    drive(1'b0, 10);
    drive(1'b1, 10);
    drive(1'b0, 300);
    chk("tmo_err", ecnt, e0 + 2);
    chk("tmo_delay", last_e - last_v, 255);
    chk("tmo_idle", 32'(O_IDLE), 1);
    chk("tmo_lock", 32'(O_LOCK), 0);
    chk("tmo_period_hold", 32'(O_PERIOD), 20);
    chk("tmo_high_hold", 32'(O_HIGH), 10);
    v1 = vcnt;
    drive(1'b1, 10);
    chk("tmo_rise_no_valid", vcnt, v1);
    chk("tmo_rise_acquire", 32'(O_IDLE), 0);
    chk("tmo_rise_period", 32'(O_PERIOD), 20);

    // Async reset mid-period while locked
    drive(1'b0, 10);
    repeat (4) per(20, 10);
    chk("ar_locked", 32'(O_LOCK), 1);
    drive(1'b1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_idle", 32'(O_IDLE), 1);
    chk("ar_lock", 32'(O_LOCK), 0);
    chk("ar_period", 32'(O_PERIOD), 0);
    chk("ar_high", 32'(O_HIGH), 0);
    chk("ar_valid", 32'(O_VALID), 0);
    S_CLK = 1'b0;
    repeat (3) @(negedge I_CLK);
    rst_n = 1'b1;
    v2 = vcnt;
    repeat (4) per(20, 10);
    chk("ar_relock_4", 32'(O_LOCK), 0);
    chk("ar_valid_cnt", vcnt, v2 + 3);
    drive(1'b1, 4);
    chk("ar_relock_5", 32'(O_LOCK), 1);

    // 40-cycle clock: error every rise after the first, never locks
    drive(1'b1, 6);
    drive(1'b0, 10);
    rst_n = 1'b0;
    repeat (2) @(negedge I_CLK);
    rst_n = 1'b1;
    e3 = ecnt; v3 = vcnt; l3 = lcnt;
    repeat (3) per(40, 20);
    drive(1'b1, 4);
    chk("slow_period", 32'(O_PERIOD), 40);
    chk("slow_high", 32'(O_HIGH), 20);
    chk("slow_errs", ecnt, e3 + 3);
    chk("slow_valids", vcnt, v3 + 3);
    chk("slow_never_lock", lcnt, l3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
